// File: rtl/cache_writeback_buffer.sv
// Write-back buffer: ring of dirty victim lines drained to memory one at a time, snooped by miss lookups.
// Lookup is combinational; evict_ready drops when full. Define WB_COALESCE_EN to merge same-address victims.
module cache_writeback_buffer #(
  parameter int address_width = 16,
  parameter int data_width    = 32,
  parameter int depth         = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       evict_valid,
  output logic                       evict_ready,
  input  logic [address_width-1:0]   evict_addr,
  input  logic [data_width-1:0]      evict_data,
  input  logic [address_width-1:0]   lookup_addr,
  output logic                       lookup_hit,
  output logic [data_width-1:0]      lookup_data,
  output logic                       mem_write_enable,
  output logic [address_width-1:0]   mem_address,
  output logic [data_width-1:0]      mem_data,
  input  logic                       mem_ack,
  output logic [$clog2(depth):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(depth);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t                     r_state;
  state_t                     w_next_state;
  logic [PW-1:0]              r_head;
  logic [PW-1:0]              r_tail;
  logic [PW:0]                r_count;
  logic [depth-1:0]           r_valid;
  logic [address_width-1:0]   r_addr [depth];
  logic [data_width-1:0]      r_data [depth];

  logic                       w_full;
  logic                       w_coal_hit;
  logic [PW-1:0]              w_coal_idx;
  logic                       w_push;
  logic                       w_alloc;
  logic                       w_pop;

  assign w_full = (r_count == (PW+1)'(depth));
  assign full   = w_full;
  assign empty  = (r_count == '0);
  assign count  = r_count;

`ifdef WB_COALESCE_EN
  // Youngest matching entry wins; the head being written is frozen until acked.
  always_comb begin : coal_scan
    logic [PW-1:0] idx;
    w_coal_hit = 1'b0;
    w_coal_idx = '0;
    for (int i = 0; i < depth; i++) begin
      idx = r_head + PW'(i);
      if (r_valid[idx] && (r_addr[idx] == evict_addr) &&
          !((r_state == S_WRITE) && (i == 0))) begin
        w_coal_hit = 1'b1;
        w_coal_idx = idx;
      end
    end
  end
  assign evict_ready = !w_full || w_coal_hit;
`else
  assign w_coal_hit  = 1'b0;
  assign w_coal_idx  = '0;
  assign evict_ready = !w_full;
`endif

  assign w_push  = evict_valid && evict_ready;
  assign w_alloc = w_push && !w_coal_hit;
  assign w_pop   = (r_state == S_WRITE) && mem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_next_state = S_WRITE;
      S_WRITE: if (mem_ack)       w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_write_enable = (r_state == S_WRITE);
    mem_address      = '0;
    mem_data         = '0;
    if (r_state == S_WRITE) begin
      mem_address = r_addr[r_head];
      mem_data    = r_data[r_head];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_alloc) begin
        r_tail          <= r_tail + 1'b1;
        r_valid[r_tail] <= 1'b1;
      end
      if (w_pop) begin
        r_head          <= r_head + 1'b1;
        r_valid[r_head] <= 1'b0;
      end
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= evict_addr;
      r_data[r_tail] <= evict_data;
    end else if (w_push && w_coal_hit) begin
      r_data[w_coal_idx] <= evict_data;
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin : lookup_scan
    logic [PW-1:0] idx;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < depth; i++) begin
      idx = r_head + PW'(i);
      if (r_valid[idx] && (r_addr[idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = r_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Directed bench for cache_writeback_buffer (default parameters).
module tb_cache_writeback_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        evict_valid;
  logic        evict_ready;
  logic [15:0] evict_addr;
  logic [31:0] evict_data;
  logic [15:0] lookup_addr;
  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic        mem_write_enable;
  logic [15:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int n_chk  = 0;
  int n_fail = 0;

  cache_writeback_buffer dut (
    .clk(clk), .reset(reset),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_addr(evict_addr), .evict_data(evict_data),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address), .mem_data(mem_data),
    .mem_ack(mem_ack), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [31:0] d);
    evict_valid = 1'b1;
    evict_addr  = a;
    evict_data  = d;
    tick();
    evict_valid = 1'b0;
  endtask

  task automatic drain_one(input string tag, input logic [15:0] ea, input logic [31:0] ed);
    int n = 0;
    while (!mem_write_enable && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_we"}, mem_write_enable, 1);
    if (mem_write_enable) begin
      chk({tag, "_addr"}, mem_address, ea);
      chk({tag, "_data"}, mem_data, ed);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
  endtask

  logic [15:0] q_addr[$];
  logic [31:0] q_data[$];

  initial begin
    reset = 1'b0; evict_valid = 1'b0; evict_addr = '0; evict_data = '0;
    lookup_addr = 16'hFFFF; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", evict_ready, 1);
    chk("rst_we", mem_write_enable, 0);
    chk("rst_maddr", mem_address, 0);
    chk("rst_mdata", mem_data, 0);
    chk("rst_hit", lookup_hit, 0);
    reset = 1'b1;
    tick();

    // single push, write held stable without ack
    push(16'h0005, 32'h11111111);
    chk("p1_count", count, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("p1_hold", {mem_write_enable, mem_address, mem_data}, {1'b1, 16'h0005, 32'h11111111});
      tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("p1_pop_count", count, 0);
    chk("p1_idle_we", mem_write_enable, 0);

    // fill to full, rejected fifth push, one ack frees a slot
    push(16'h0005, 32'hA0A0A0A0);
    push(16'h0105, 32'hA1A1A1A1);
    push(16'h0205, 32'hA2A2A2A2);
    push(16'h0305, 32'hA3A3A3A3);
    chk("full_count", count, 4);
    chk("full_flag", full, 1);
    chk("full_ready", evict_ready, 0);
    push(16'h0405, 32'hA4A4A4A4);
    chk("full_rej_count", count, 4);
    lookup_addr = 16'h0405;
    #1;
    chk("full_rej_hit", lookup_hit, 0);
    drain_one("full_d0", 16'h0005, 32'hA0A0A0A0);
    chk("full_pop_count", count, 3);
    chk("full_pop_ready", evict_ready, 1);
    chk("full_pop_full", full, 0);
    drain_one("full_d1", 16'h0105, 32'hA1A1A1A1);
    drain_one("full_d2", 16'h0205, 32'hA2A2A2A2);
    drain_one("full_d3", 16'h0305, 32'hA3A3A3A3);
    chk("full_empty", empty, 1);

    // combinational lookup
    push(16'h0105, 32'h22222222);
    lookup_addr = 16'h0105;
    #1;
    chk("lk_hit", lookup_hit, 1);
    chk("lk_data", lookup_data, 32'h22222222);
    lookup_addr = 16'h0405;
    #1;
    chk("lk_miss_hit", lookup_hit, 0);
    chk("lk_miss_data", lookup_data, 0);
    drain_one("lk_d", 16'h0105, 32'h22222222);
    lookup_addr = 16'h0105;
    #1;
    chk("lk_gone", lookup_hit, 0);

    // duplicate address behind a different head
    push(16'h0300, 32'h33333333);
    push(16'h0005, 32'hAAAAAAAA);
    push(16'h0005, 32'hBBBBBBBB);
    lookup_addr = 16'h0005;
    #1;
    chk("dup_lookup", lookup_data, 32'hBBBBBBBB);
`ifdef WB_COALESCE_EN
    chk("dup_count", count, 2);
    drain_one("dup_d0", 16'h0300, 32'h33333333);
    drain_one("dup_d1", 16'h0005, 32'hBBBBBBBB);
`else
    chk("dup_count", count, 3);
    drain_one("dup_d0", 16'h0300, 32'h33333333);
    drain_one("dup_d1", 16'h0005, 32'hAAAAAAAA);
    drain_one("dup_d2", 16'h0005, 32'hBBBBBBBB);
`endif
    chk("dup_empty", empty, 1);

    // reset asserted mid-write
    push(16'h0010, 32'h00000001);
    push(16'h0020, 32'h00000002);
    push(16'h0030, 32'h00000003);
    chk("mr_we_before", mem_write_enable, 1);
    #1 reset = 1'b0;
    #1;
    chk("mr_we", mem_write_enable, 0);
    chk("mr_count", count, 0);
    chk("mr_maddr", mem_address, 0);
    chk("mr_ready", evict_ready, 1);
    lookup_addr = 16'h0010;
    #1;
    chk("mr_hit", lookup_hit, 0);
    tick();
    reset = 1'b1;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("mr_ack_count", count, 0);
    chk("mr_ack_we", mem_write_enable, 0);
    chk("mr_ack_empty", empty, 1);

    // three wrap-arounds with continuous push and ack
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic acc;
          int   g;
          g = 0;
          evict_valid = 1'b1;
          evict_addr  = 16'h1000 + 16'(i * 16);
          evict_data  = 32'hC0DE0000 + 32'(i);
          do begin
            #1 acc = evict_ready;
            @(posedge clk);
            #1;
            g++;
          end while (!acc && g < 100);
        end
        evict_valid = 1'b0;
      end
      begin
        int cyc;
        cyc = 0;
        while (q_addr.size() < 12 && cyc < 400) begin
          @(posedge clk);
          #1;
          cyc++;
          chk("ring_cnt_le_depth", (count <= 3'd4), 1);
          if (mem_write_enable && !mem_ack) begin
            q_addr.push_back(mem_address);
            q_data.push_back(mem_data);
            mem_ack = 1'b1;
          end else begin
            mem_ack = 1'b0;
          end
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
      end
    join
    chk("ring_nwrites", q_addr.size(), 12);
    for (int i = 0; i < q_addr.size() && i < 12; i++) begin
      chk("ring_addr", q_addr[i], 16'h1000 + 16'(i * 16));
      chk("ring_data", q_data[i], 32'hC0DE0000 + 32'(i));
    end
    chk("ring_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_writeback_buffer.md
CACHE_WRITEBACK_BUFFER -- requirements
Module: cache_writeback_buffer

Interface
REQ-001 Parameter address_width, default 16, SHALL set the byte-address width of every address port.
REQ-002 Parameter data_width, default 32, SHALL set the width of every data port.
REQ-003 Parameter depth, default 4, SHALL set the number of buffered dirty lines, power of two, minimum 2.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  SHALL be the reset: asynchronous and active-low.
REQ-006 evict_valid  input  1  SHALL mark a dirty victim line offered by the cache controller.
REQ-007 evict_ready  output  1  SHALL indicate that the buffer accepts the offered victim.
REQ-008 evict_addr  input  address_width  SHALL carry the victim line address.
REQ-009 evict_data  input  data_width  SHALL carry the victim line data.
REQ-010 lookup_addr  input  address_width  SHALL carry the cache miss address to be snooped.
REQ-011 lookup_hit / lookup_data  output  1 / data_width  SHALL return the buffered data for lookup_addr on a match.
REQ-012 mem_write_enable  output  1  SHALL be the write request to main memory.
REQ-013 mem_address / mem_data  output  address_width / data_width  SHALL carry the head entry being written.
REQ-014 mem_ack  input  1  SHALL be the one-cycle completion pulse from main memory.
REQ-015 count  output  clog2(depth)+1  SHALL report the number of occupied entries; full and empty (1 each) SHALL be count==depth and count==0.

Function
REQ-016 The buffer SHALL be a circular FIFO with head and tail pointers that wrap modulo depth.
REQ-017 evict_ready SHALL equal !full from registered state; a pop in the same cycle SHALL NOT make room for a push.
REQ-018 A push SHALL occur on a clock edge where evict_valid && evict_ready; the entry SHALL be visible to lookup in the next cycle.
REQ-019 The drain FSM SHALL have two states: IDLE and WRITE.
REQ-020 IDLE -> WRITE SHALL occur when count != 0; in WRITE, mem_write_enable SHALL be 1 and mem_address/mem_data SHALL hold the head entry, stable until mem_ack.
REQ-021 On mem_ack in WRITE, the head SHALL pop and the FSM SHALL return to IDLE; the minimum gap between consecutive writes SHALL be one IDLE cycle.
REQ-022 mem_ack while in IDLE SHALL be ignored.
REQ-023 A simultaneous push and pop SHALL leave count unchanged.
REQ-024 lookup_hit SHALL be combinational; when several entries match, lookup_data SHALL be the youngest match, including the head entry in WRITE.
REQ-025 When lookup_hit is 0, lookup_data SHALL be 0.

Reset
REQ-026 While reset is 0, the following SHALL be cleared asynchronously: pointers, count=0, empty=1, full=0, evict_ready=1, FSM=IDLE, mem_write_enable=0, mem_address=0, mem_data=0, all valid bits=0.
REQ-027 Reset during WRITE SHALL drop mem_write_enable immediately and discard all buffered lines; a later mem_ack SHALL be ignored.

Configuration
REQ-028 Macro WB_COALESCE_EN defined: a push whose evict_addr matches a valid entry other than the head in WRITE SHALL overwrite that entry's data in place, leaving count unchanged. In this case evict_ready SHALL be 1 even when the buffer is full.
REQ-029 Macro WB_COALESCE_EN undefined: every push SHALL allocate a new entry, and duplicate addresses SHALL be drained in order.

Verification
REQ-030 Reset, then push 0x0005/0x11111111 with mem_ack held 0 -> count=1 next cycle; mem_write_enable=1 with mem_address=0x0005 and mem_data=0x11111111; they stay stable for 10 cycles.
REQ-031 Push 0x0005, 0x0105, 0x0205 and 0x0305 with mem_ack=0 -> full=1 and evict_ready=0; a fifth push of 0x0405 is not accepted; one mem_ack -> pop of 0x0005 and evict_ready=1.
REQ-032 Buffer 0x0105/0x22222222, then set lookup_addr=0x0105 -> lookup_hit=1 and lookup_data=0x22222222 in the same cycle; lookup_addr=0x0405 -> lookup_hit=0 and lookup_data=0.
REQ-033 Push 0x0005/0xAAAAAAAA, then 0x0005/0xBBBBBBBB while the head is not 0x0005 -> with WB_COALESCE_EN: count up by 1 and one memory write of 0xBBBBBBBB; without it: count up by 2, writes in order AAAA then BBBB, and lookup returns 0xBBBBBBBB.
REQ-034 Assert reset low mid-WRITE with 3 entries buffered -> mem_write_enable=0 asynchronously and count=0; a mem_ack after reset release causes no pop.
REQ-035 Run the ring through 3 full wrap-arounds with continuous push and ack -> the memory writes match the push order exactly and count never exceeds depth.
